// File: rtl/otter_uart_pkg.sv
// Shared constants for the OTTER IOBUS UART transmitter: register offsets,
// STATUS bit layout and the serialiser state encoding.
package otter_uart_pkg;

   // Word offsets within the 16-byte register window (IOBUS_ADDR[3:2])
   localparam logic [1:0] OFS_TXDATA  = 2'd0;
   localparam logic [1:0] OFS_STATUS  = 2'd1;
   localparam logic [1:0] OFS_DIVISOR = 2'd2;
   localparam logic [1:0] OFS_CTRL    = 2'd3;

   // STATUS register layout
   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;
   localparam int ST_CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/otter_sync_fifo.sv
// Single-clock show-ahead FIFO. Pointers wrap modulo DEPTH (power of two);
// the extra count bit separates full from empty. Push when full and pop when
// empty are ignored, so callers may gate or not.
module otter_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; push+pop together leaves count alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset: contents are only visible through the pointers
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/otter_iobus_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter: register window decode, transmit FIFO,
// bit-timed serialiser and a drain interrupt toward the MCU.
module otter_iobus_uart_tx
   import otter_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] IOBUS_IN,
   output logic        TX,
   output logic        IRQ
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          sel;
   logic [1:0]    ofs;
   logic          wr_txdata, wr_status, wr_div, wr_ctrl;
   logic [15:0]   divisor_q;
   logic          irq_en_q;
   logic          ovf_q;
   logic          fifo_push, fifo_pop;
   logic [7:0]    fifo_dout;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [ST_CNT_W-1:0] cnt_field;
   tx_state_e     state_q, state_d;
   logic [15:0]   bit_cnt_q;
   logic [15:0]   div_lat_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic          bit_end;
   logic          busy;
   logic [31:0]   status_w;
   logic [31:0]   rd_data;
   logic          unused_ok;

   assign unused_ok = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:16]};

   assign sel       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
   assign ofs       = IOBUS_ADDR[3:2];
   assign wr_txdata = IOBUS_WR & sel & (ofs == OFS_TXDATA);
   assign wr_status = IOBUS_WR & sel & (ofs == OFS_STATUS);
   assign wr_div    = IOBUS_WR & sel & (ofs == OFS_DIVISOR);
   assign wr_ctrl   = IOBUS_WR & sel & (ofs == OFS_CTRL);

   // Full is the registered flag, so a write in the same cycle as a pop of a
   // full FIFO is still dropped.
   assign fifo_push = wr_txdata & ~fifo_full;

   otter_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (IOBUS_OUT[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // STATUS count field saturates if the FIFO count is wider than the field
   if (CW > ST_CNT_W) begin : g_cnt_sat
      assign cnt_field = (fifo_count > CW'(15)) ? 4'hF : fifo_count[ST_CNT_W-1:0];
   end else begin : g_cnt_ext
      assign cnt_field = ST_CNT_W'(fifo_count);
   end

   // Configuration registers and sticky overflow
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         divisor_q <= DEFAULT_DIV;
         irq_en_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         if (wr_div)  divisor_q <= IOBUS_OUT[15:0];
         if (wr_ctrl) irq_en_q  <= IOBUS_OUT[0];
         if (wr_txdata && fifo_full)             ovf_q <= 1'b1;
         else if (wr_status && IOBUS_OUT[ST_OVF]) ovf_q <= 1'b0;
      end
   end

   assign busy    = (state_q != IDLE);
   assign bit_end = (bit_cnt_q == 16'd0);
   assign IRQ     = irq_en_q & fifo_empty & ~busy;

   // STATUS word assembled from registered state only
   always_comb begin
      status_w = '0;
      status_w[ST_BUSY]  = busy;
      status_w[ST_FULL]  = fifo_full;
      status_w[ST_EMPTY] = fifo_empty;
      status_w[ST_OVF]   = ovf_q;
      status_w[ST_CNT_LSB +: ST_CNT_W] = cnt_field;
   end

   // Read mux; unselected addresses and TXDATA read as zero
   always_comb begin
      rd_data = '0;
      if (sel) begin
         case (ofs)
            OFS_STATUS:  rd_data = status_w;
            OFS_DIVISOR: rd_data = {16'h0, divisor_q};
            OFS_CTRL:    rd_data = {31'h0, irq_en_q};
            default:     rd_data = '0;
         endcase
      end
   end

   // One-cycle registered read path
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) IOBUS_IN <= '0;
      else        IOBUS_IN <= rd_data;
   end

   // Serialiser state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and FIFO pop; STOP chains straight into START when data waits
   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = START;
            end
         end
         START: if (bit_end) state_d = DATA;
         DATA:  if (bit_end && bit_idx_q == 3'd7) state_d = STOP;
         STOP: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bit timing and shift register; divisor is latched per frame at pop
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bit_cnt_q <= '0;
         div_lat_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else if (fifo_pop) begin
         shift_q   <= fifo_dout;
         div_lat_q <= divisor_q;
         bit_cnt_q <= divisor_q;
         bit_idx_q <= '0;
      end else if (busy) begin
         if (bit_end) begin
            bit_cnt_q <= div_lat_q;
            if (state_q == DATA) begin
               shift_q   <= {1'b0, shift_q[7:1]};
               bit_idx_q <= bit_idx_q + 3'd1;
            end
         end else begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
         end
      end
   end

   // Line level follows state; reset returns to IDLE so TX rises at once
   always_comb begin
      case (state_q)
         START:   TX = 1'b0;
         DATA:    TX = shift_q[0];
         default: TX = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// Scoreboard bench for otter_iobus_uart_tx. Stimulus queues expected read
// data, expected TX bytes and direct pin expectations; a negedge monitor
// decodes TX frames cycle by cycle and does all comparisons.
module tb_otter_iobus_uart_tx;

   localparam logic [31:0] A_TX   = 32'h1100_0100;
   localparam logic [31:0] A_ST   = 32'h1100_0104;
   localparam logic [31:0] A_DIV  = 32'h1100_0108;
   localparam logic [31:0] A_CTRL = 32'h1100_010C;
   localparam logic [31:0] A_UNSEL = 32'h1100_0208;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic [31:0] IOBUS_ADDR = '0;
   logic [31:0] IOBUS_OUT = '0;
   logic        IOBUS_WR = 1'b0;
   logic [31:0] IOBUS_IN;
   logic        TX;
   logic        IRQ;

   otter_iobus_uart_tx #(
      .BASE_ADDR(32'h1100_0100), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd867)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
      .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .TX(TX), .IRQ(IRQ)
   );

   always #5 CLK = ~CLK;

   // Scoreboard queues (stimulus pushes, monitor pops)
   string       dchk_nm[$];
   logic [31:0] dchk_act[$];
   logic [31:0] dchk_exp[$];
   string       rd_nm[$];
   logic [31:0] rd_exp[$];
   logic [7:0]  tx_q[$];

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   logic rd_req = 1'b0;
   logic rd_req_q = 1'b0;
   int   mon_div = 867;
   bit   chk_contig = 1'b0;

   bit         m_active = 1'b0;
   bit         m_have_prev = 1'b0;
   bit         m_unexp;
   int         m_t0, m_div, m_bad, m_prev_end;
   logic [7:0] m_got, m_exp;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(posedge CLK) rd_req_q <= rd_req;

   // Monitor: pin checks, read data one cycle after the address, TX frames
   always @(negedge CLK) begin
      int   off, bi, pos;
      logic lvl;
      cyc = cyc + 1;
      while (dchk_nm.size() > 0)
         cmp(dchk_nm.pop_front(), dchk_act.pop_front(), dchk_exp.pop_front());
      if (rd_req_q && rd_nm.size() > 0)
         cmp(rd_nm.pop_front(), IOBUS_IN, rd_exp.pop_front());
      if (!RST_N) begin
         m_active    = 1'b0;
         m_have_prev = 1'b0;
      end else begin
         if (!m_active && TX == 1'b0) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_div    = mon_div;
            m_bad    = 0;
            m_got    = '0;
            m_unexp  = (tx_q.size() == 0);
            m_exp    = m_unexp ? 8'h00 : tx_q[0];
            cmp("frame_expected", {31'd0, m_unexp}, 32'd0);
            if (chk_contig && m_have_prev) cmp("contiguous_start", cyc, m_prev_end + 1);
         end
         if (m_active) begin
            off = cyc - m_t0;
            bi  = off / (m_div + 1);
            pos = off % (m_div + 1);
            lvl = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : m_exp[bi-1];
            if (TX !== lvl) m_bad++;
            if (bi >= 1 && bi <= 8 && pos == m_div / 2) m_got[bi-1] = TX;
            if (off == 10 * (m_div + 1) - 1) begin
               if (!m_unexp) begin
                  void'(tx_q.pop_front());
                  cmp("frame", {m_bad[15:0], 8'h00, m_got}, {16'h0, 8'h00, m_exp});
               end
               m_active    = 1'b0;
               m_prev_end  = cyc;
               m_have_prev = 1'b1;
            end
         end
      end
   end

   task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      dchk_nm.push_back(nm);
      dchk_act.push_back(act);
      dchk_exp.push_back(exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      IOBUS_ADDR = a;
      IOBUS_OUT  = d;
      IOBUS_WR   = 1'b1;
      @(posedge CLK);
      #1;
      IOBUS_WR   = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit xmit);
      wr(A_TX, {24'h0, b});
      if (xmit) tx_q.push_back(b);
   endtask

   task automatic rd(input logic [31:0] a, input string nm, input logic [31:0] e);
      IOBUS_ADDR = a;
      rd_req     = 1'b1;
      rd_nm.push_back(nm);
      rd_exp.push_back(e);
      @(posedge CLK);
      #1;
      rd_req = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((tx_q.size() != 0 || m_active) && n < budget) begin
         idle(1);
         n++;
      end
      dchk("drain", 32'(tx_q.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 RST_N = 1'b0;
      #20;
      dchk("rst_tx", {31'd0, TX}, 32'd1);
      dchk("rst_irq", {31'd0, IRQ}, 32'd0);
      dchk("rst_rdata", IOBUS_IN, 32'd0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      idle(1);

      // Reset values and decode
      rd(A_ST,   "rst_status", 32'h4);
      rd(A_DIV,  "rst_div",    32'd867);
      rd(A_CTRL, "rst_ctrl",   32'd0);
      rd(A_TX,   "txdata_read", 32'd0);
      wr(A_UNSEL, 32'h5);
      rd(A_UNSEL, "unsel_read", 32'd0);
      rd(A_DIV,  "unsel_wr_ignored", 32'd867);

      // Single byte 0xA5 at 4 clocks/bit
      wr(A_DIV, 32'd3);
      mon_div = 3;
      rd(A_DIV, "div_rw", 32'd3);
      send(8'hA5, 1'b1);
      dchk("lat_tx_high", {31'd0, TX}, 32'd1);
      idle(1);
      dchk("lat_tx_low", {31'd0, TX}, 32'd0);
      idle(20);
      rd(A_ST, "st_busy_single", 32'h5);
      drain(200);
      idle(2);
      rd(A_ST, "st_done_single", 32'h4);

      // Back-to-back: a leading byte occupies the serialiser so the three
      // test bytes sit in the FIFO together; the second push coincides with
      // the first pop.
      send(8'h3C, 1'b1);
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      send(8'h55, 1'b1);
      chk_contig = 1'b1;
      idle(16);
      rd(A_ST, "st_cnt3", 32'h301);
      idle(39);
      rd(A_ST, "st_cnt2", 32'h201);
      idle(39);
      rd(A_ST, "st_cnt1", 32'h101);
      idle(39);
      rd(A_ST, "st_cnt0", 32'h005);
      drain(200);
      chk_contig = 1'b0;
      idle(2);
      rd(A_ST, "st_done_b2b", 32'h4);

      // Overflow: first byte goes straight to the serialiser, the next eight
      // fill the FIFO, the last is dropped.
      wr(A_DIV, 32'd100);
      mon_div = 100;
      send(8'h01, 1'b1);
      for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b1);
      send(8'hEE, 1'b0);
      rd(A_ST, "st_overflow", 32'h80B);
      wr(A_ST, 32'h8);
      rd(A_ST, "st_ovf_clear", 32'h803);
      drain(12000);
      idle(2);
      rd(A_ST, "st_done_ovf", 32'h4);

      // Interrupt
      wr(A_DIV, 32'd3);
      mon_div = 3;
      wr(A_CTRL, 32'd1);
      dchk("irq_idle_en", {31'd0, IRQ}, 32'd1);
      rd(A_CTRL, "ctrl_rw", 32'd1);
      send(8'h96, 1'b1);
      dchk("irq_pending", {31'd0, IRQ}, 32'd0);
      idle(10);
      dchk("irq_busy", {31'd0, IRQ}, 32'd0);
      drain(200);
      idle(2);
      dchk("irq_done", {31'd0, IRQ}, 32'd1);
      wr(A_CTRL, 32'd0);
      dchk("irq_off", {31'd0, IRQ}, 32'd0);

      // Reset during a low DATA bit (bit 2 of 0xC3)
      send(8'hC3, 1'b1);
      idle(14);
      dchk("pre_rst_tx", {31'd0, TX}, 32'd0);
      RST_N = 1'b0;
      #1;
      dchk("rst_async_tx", {31'd0, TX}, 32'd1);
      tx_q.delete();
      idle(2);
      RST_N = 1'b1;
      mon_div = 867;
      idle(2);
      rd(A_ST,  "post_rst_status", 32'h4);
      rd(A_DIV, "post_rst_div", 32'd867);
      idle(100);
      dchk("post_rst_tx_idle", {31'd0, TX}, 32'd1);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
